gpr_writeback: RTL and testbench

GPR_WRITEBACK -- requirements
Module: gpr_writeback

---
 rtl/gpr_writeback.sv | 113 +++++++++++
 tb/tb_gpr_writeback.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_writeback.sv
// gpr_writeback: arbitrates ALU and load-unit results onto a single
// register-file write port and tracks pending destination registers.
// The load unit has priority. The ALU is forced through after it has lost
// three consecutive contended cycles.
module gpr_writeback #(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                alu_valid,
  input  logic [4:0]          alu_rd,
  input  logic [WordSize-1:0] alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [4:0]          mem_rd,
  input  logic [WordSize-1:0] mem_data,
  output logic                mem_ready,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rd,
  input  logic                flush,
  output logic                wbe,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] rdd,
  output logic [31:0]         busy
);

  logic [1:0]          starve_cnt;
  logic                alu_grant;
  logic                mem_grant;
  logic                hs;
  logic [4:0]          hs_rd;
  logic [WordSize-1:0] hs_data;
  logic [31:0]         busy_q;
  logic [31:0]         busy_next;

  // Grant selection: the load unit wins unless the ALU has starved for three cycles.
  // Nothing is granted while reset is held, so results offered then are not taken.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (rstn) begin
      if (alu_valid && (!mem_valid || (starve_cnt == 2'd3))) begin
        alu_grant = 1'b1;
      end else if (mem_valid) begin
        mem_grant = 1'b1;
      end
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;
  assign hs        = alu_grant | mem_grant;
  assign hs_rd     = mem_grant ? mem_rd : alu_rd;
  assign hs_data   = mem_grant ? mem_data : alu_data;

  // Starvation counter: counts contended cycles the ALU loses. It cannot pass 3,
  // because a count of 3 with the ALU still waiting forces an ALU grant that clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 2'd0;
    end else if (alu_grant || !alu_valid) begin
      starve_cnt <= 2'd0;
    end else if (mem_grant) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end

  // Writeback stage: one-cycle registered copy of the accepted result.
  // Writes to x0 complete the handshake but never raise the write enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbe <= 1'b0;
      rdn <= 5'd0;
      rdd <= '0;
    end else begin
      wbe <= hs && (hs_rd != 5'd0);
      if (hs) begin
        rdn <= hs_rd;
        rdd <= hs_data;
      end
    end
  end

  // Pending-register update. Flush beats everything. Otherwise a new issue beats a
  // completing writeback to the same register, because the newer producer is
  // still outstanding.
  always_comb begin
    busy_next = busy_q;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (hs) begin
        busy_next[hs_rd] = 1'b0;
      end
      if (issue_valid) begin
        busy_next[issue_rd] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
  end

  // Pending-register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_gpr_writeback.sv
// Bench for gpr_writeback. A driver applies a result/issue pattern at every
// negedge and pushes the expected writeback and pending flags into queues.
// A monitor samples just after each posedge and pops and compares them.
module tb_gpr_writeback;

  logic        clk;
  logic        rstn;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        wbe;
  logic [4:0]  rdn;
  logic [31:0] rdd;
  logic [31:0] busy;

  gpr_writeback #(.WordSize(32)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .wbe(wbe), .rdn(rdn), .rdd(rdd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    int          cyc;
    logic [31:0] v;
  } busy_t;

  wb_t   wb_q[$];
  busy_t busy_q[$];

  int    checks   = 0;
  int    failures = 0;
  int    edge_cnt = 0;
  bit    in_reset = 1'b1;

  // Reference state: the pending set and how many contended cycles the ALU has lost.
  bit    pend[32];
  int    alu_losses = 0;
  logic  last_mem_ready;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    alu_losses = 0;
    wb_q.delete();
    busy_q.delete();
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird, input logic fl);
    bit    take_alu;
    bit    take_mem;
    wb_t   w;
    busy_t b;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    issue_valid = iv; issue_rd = ird; flush = fl;
    #1;
    take_alu = av && (!mv || alu_losses >= 3);
    take_mem = mv && !take_alu;
    check("alu_ready", alu_ready, take_alu);
    check("mem_ready", mem_ready, take_mem);
    last_mem_ready = mem_ready;
    if (take_alu || take_mem) begin
      w.cyc  = edge_cnt + 1;
      w.rd   = take_mem ? mrd : ard;
      w.data = take_mem ? md : ad;
      if (w.rd != 0) wb_q.push_back(w);
      pend[w.rd] = 1'b0;
    end
    if (iv) pend[ird] = 1'b1;
    if (fl) for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    pend[0] = 1'b0;
    b.cyc = edge_cnt + 1;
    b.v   = pend_vec();
    busy_q.push_back(b);
    if (take_alu || !av) alu_losses = 0;
    else alu_losses++;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: compares the registered writeback and the pending flags after every edge.
  initial begin
    wb_t   e;
    busy_t b;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset) begin
        while (wb_q.size() > 0 && wb_q[0].cyc < edge_cnt) begin
          e = wb_q.pop_front();
          checks++;
          failures++;
          $display("FAIL wb_missed actual=none required=rd%0d/0x%0h", e.rd, e.data);
        end
        if (wb_q.size() > 0 && wb_q[0].cyc == edge_cnt) begin
          e = wb_q.pop_front();
          check("wbe", wbe, 1'b1);
          check("rdn", rdn, e.rd);
          check("rdd", rdd, e.data);
        end else begin
          check("wbe_idle", wbe, 1'b0);
        end
        if (busy_q.size() > 0 && busy_q[0].cyc == edge_cnt) begin
          b = busy_q.pop_front();
          check("busy", busy, b.v);
        end
      end
    end
  end

  initial begin
    logic [4:0] contention_pat;
    contention_pat = 5'b10111;
    clear_model();
    rstn = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h5678;
    issue_valid = 1'b1; issue_rd = 5'd5; flush = 1'b0;
    #23;
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_wbe", wbe, 1'b0);
    check("rst_rdn", rdn, 5'd0);
    check("rst_rdd", rdd, 32'd0);
    check("rst_busy", busy, 32'd0);
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    rstn = 1'b1;
    in_reset = 1'b0;

    // Single ALU result
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    idle();
    idle();

    // Contention: load unit wins three times, then the ALU is forced through
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd2, 32'hA000 + i, 1'b1, 5'd1, 32'hB000 + i, 1'b0, 5'd0, 1'b0);
      check("contention_grant", last_mem_ready, contention_pat[i]);
    end
    idle();
    idle();

    // Pending flags: set, cleared by load, and re-issue on the completing edge
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7, 1'b0);
    idle();

    // Zero register
    drive(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0);
    idle();

    // Writeback to a register that is not pending
    drive(1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    idle();

    // Flush with an in-flight writeback and a simultaneous issue
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 1'b1);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 5'($urandom % (($urandom % 4 == 0) ? 32 : 8)), $urandom,
            ($urandom % 2) != 0, 5'($urandom % 8), $urandom,
            ($urandom % 2) != 0, 5'($urandom % 8), ($urandom % 25) == 0);
    end
    idle();
    idle();

    // Reset right after a handshake to rd 6
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 1'b0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    in_reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    #1;
    check("midrst_wbe", wbe, 1'b0);
    check("midrst_busy", busy, 32'd0);
    check("midrst_rdn", rdn, 5'd0);
    clear_model();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    in_reset = 1'b0;
    idle();
    idle();
    idle();
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd8, 1'b0);
    idle();
    idle();

    @(negedge clk);
    check("wb_queue_drained", wb_q.size(), 0);
    check("busy_queue_drained", busy_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
